tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
// - Receive end of a time-division multiplexed link. A round-robin MUX sender puts one channel sample per valid beat.
// - This block locks to frame_sync and steers each sample to its channel register.
// - It snapshots each complete frame and flags framing errors.
// - Sits between the serial sample bus and the per-channel consumers.
// PARAMETERS
// - N_CH   4  channels per frame; legal range >= 2.
// - W      8  sample width in bits.
// - CW     $clog2(N_CH)  channel index width; derived, never overridden.
// PORTS
// - clk         in   1        single clock; all state updates on rising edge.
// - rst_n       in   1        synchronous, active-low reset, sampled on rising clk.
// - din         in   W        serial sample.
// - din_valid   in   1        din carries a sample this cycle.
// - frame_sync  in   1        qualified by din_valid: this sample is channel 0.
// - dout        out  N_CH*W   live channel registers; channel k in bits [k*W +: W].
// - ch_valid    out  N_CH     one-hot, 1-cycle pulse: channel k register written last edge.
// - frame_q     out  N_CH*W   snapshot of the last complete frame.
// - frame_done  out  1        1-cycle pulse: frame_q updated.
// - sync_err    out  1        1-cycle pulse: frame_sync arrived with ch_cnt != 0 while LOCKED.
// - locked      out  1        high in LOCKED state.
// - ch_cnt      out  CW       channel index for the next sample.
// BEHAVIOUR
// - Reset (rst_n=0 at an edge):
//   - All outputs and registers go to 0; state goes to HUNT.
//   - Reset mid-frame discards the partial frame; frame_q is cleared.
// - Samples are taken only when din_valid=1. frame_sync with din_valid=0 is ignored.
// - HUNT state:
//   - din_valid && !frame_sync: sample discarded, no outputs change.
//   - din_valid && frame_sync: dout[ch0] <= din, ch_valid <= 1, ch_cnt <= 1, go to LOCKED.
// - LOCKED state, din_valid && !frame_sync:
//   - dout[ch_cnt] <= din; ch_valid <= one-hot(ch_cnt).
//   - ch_cnt increments, wrapping N_CH-1 -> 0.
//   - When ch_cnt == N_CH-1: frame_q <= dout with slot N_CH-1 replaced by din, so the snapshot includes the current sample.
//   - In that same cycle frame_done <= 1.
// - LOCKED state, din_valid && frame_sync:
//   - If ch_cnt == 0: normal channel-0 write.
//   - Otherwise: sync_err <= 1. The sample is written to ch0 and ch_cnt <= 1 (realign). frame_q is NOT updated, and the partial frame is dropped.
//   - Stays LOCKED.
// - Latency: input sample to dout/ch_valid is 1 clk. To frame_q/frame_done, 1 clk after the last channel.
// - ch_valid, frame_done and sync_err are all 0 on any cycle without a sample.
// - dout holds its value between writes; frame_q holds between frames.
// - Back-to-back valid beats are supported every cycle; no backpressure.
// STRUCTURE
// - Shared include tdm_defs.vh:
//   - state encodings ST_HUNT=1'b0, ST_LOCKED=1'b1.
//   - default N_CH and W, so the matching tdm_mux sender uses the same values.
// - Sub-module tdm_ch_counter (CW bits). Inputs: clear, load1, inc. Output: cnt, plus wrap flag at N_CH-1.
// - Top level holds the FSM, the dout/frame_q register banks and the pulse registers.
// TESTING (N_CH=4, W=8)
// 1. Reset: hold rst_n=0 for 2 clks -> all outputs 0, locked=0. Send din=8'hAA, valid=1, sync=0 -> no change.
// 2. Lock and fill:
//    - Stimulus: sync+8'h11, then 8'h22, 8'h33, 8'h44 on consecutive cycles.
//    - ch_valid sequence 0001, 0010, 0100, 1000.
//    - frame_done pulses once, and frame_q = {44,33,22,11} (ch3..ch0).
// 3. Wrap: after test 2, send 8'h55 without sync -> ch0=8'h55, ch_cnt=1, no sync_err.
// 4. Early sync:
//    - After 2 samples of a frame, send sync+8'h66 -> sync_err pulses 1 clk, ch0=8'h66, ch_cnt=1.
//    - frame_q is unchanged.
// 5. Gaps: insert din_valid=0 cycles between samples -> no pulses in gap cycles; frame completes after 4 valid beats.
// 6. Reset mid-frame: assert rst_n=0 after ch1 write -> all cleared, HUNT. Unsynced samples are ignored until the next sync.

Source files
------------

// File: rtl/tdm_demux_pkg.sv
// tdm_demux_pkg
//   Definitions shared by the TDM receive path and its matching sender:
//   FSM state encodings and the default frame geometry.
package tdm_demux_pkg;

  // Default geometry; the tdm_mux sender picks up the same values.
  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/tdm_demux_if.sv
// tdm_demux_if
//   Serial sample bus of the TDM link.
//   din        : one channel sample per valid beat
//   din_valid  : din carries a sample this cycle
//   frame_sync : qualified by din_valid, marks the channel-0 sample
//   master modport drives the bus (sender), slave modport receives it.
interface tdm_demux_if
  import tdm_demux_pkg::*;
#(
  parameter int W = W_DEF
) ();

  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;

  modport master (output din, output din_valid, output frame_sync);
  modport slave  (input  din, input  din_valid, input  frame_sync);

endinterface

// File: rtl/tdm_ch_counter.sv
// tdm_ch_counter
//   Channel index counter for the TDM demux.
//   clk   : clock
//   clear : synchronous clear to 0 (highest priority)
//   load1 : load 1 (the sample just taken was channel 0)
//   inc   : advance, wrapping N_CH-1 -> 0
//   cnt   : channel index of the next sample
//   wrap  : cnt currently equals N_CH-1
module tdm_ch_counter
  import tdm_demux_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = CW'(1);
    end else if (inc) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux
//   Receive end of a TDM link. Locks to frame_sync, steers each valid
//   sample into its channel register, snapshots every complete frame and
//   flags a frame_sync that arrives mid-frame.
//   clk        : clock, all state on rising edge
//   rst_n      : synchronous active-low reset
//   bus        : serial sample bus (slave side)
//   dout       : live channel registers, channel k in [k*W +: W]
//   ch_valid   : one-hot pulse, channel register written on last edge
//   frame_q    : snapshot of the last complete frame
//   frame_done : pulse, frame_q updated
//   sync_err   : pulse, frame_sync seen with ch_cnt != 0 while locked
//   locked     : FSM is in LOCKED
//   ch_cnt     : channel index of the next sample
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter  int N_CH = N_CH_DEF,
  parameter  int W    = W_DEF,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  tdm_demux_if.slave        bus,
  output logic [N_CH*W-1:0] dout,
  output logic [N_CH-1:0]   ch_valid,
  output logic [N_CH*W-1:0] frame_q,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked,
  output logic [CW-1:0]     ch_cnt
);

  tdm_state_e          state_q, state_d;
  logic [N_CH*W-1:0]   dout_q, dout_d;
  logic [N_CH-1:0]     ch_valid_q, ch_valid_d;
  logic [N_CH*W-1:0]   frame_q_q, frame_q_d;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q, sync_err_d;

  logic                cnt_load1;
  logic                cnt_inc;
  logic                cnt_wrap;

  // Reset doubles as the counter clear so the index restarts with the FSM.
  tdm_ch_counter #(.N_CH(N_CH)) u_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .cnt   (ch_cnt),
    .wrap  (cnt_wrap)
  );

  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    ch_valid_d   = '0;
    frame_q_d    = frame_q_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    cnt_load1    = 1'b0;
    cnt_inc      = 1'b0;

    if (bus.din_valid) begin
      if (bus.frame_sync) begin
        // Sync always realigns to channel 0; in LOCKED a nonzero index means
        // the partial frame is abandoned without touching frame_q.
        dout_d[0 +: W] = bus.din;
        ch_valid_d[0]  = 1'b1;
        cnt_load1      = 1'b1;
        sync_err_d     = (state_q == ST_LOCKED) && (ch_cnt != '0);
        state_d        = ST_LOCKED;
      end else if (state_q == ST_LOCKED) begin
        dout_d[ch_cnt*W +: W] = bus.din;
        ch_valid_d[ch_cnt]    = 1'b1;
        cnt_inc               = 1'b1;
        if (cnt_wrap) begin
          // Snapshot must include the sample arriving this cycle.
          frame_q_d                  = dout_q;
          frame_q_d[(N_CH-1)*W +: W] = bus.din;
          frame_done_d               = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      dout_q       <= '0;
      ch_valid_q   <= '0;
      frame_q_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      ch_valid_q   <= ch_valid_d;
      frame_q_q    <= frame_q_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign ch_valid   = ch_valid_q;
  assign frame_q    = frame_q_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux
//   Scoreboard bench for tdm_demux (N_CH=4, W=8). Each beat computes the
//   expected register state from a behavioural model of the link, pushes it
//   to a queue, clocks the DUT and pops/compares after the edge.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH*W-1:0] dout;
  logic [N_CH-1:0]   ch_valid;
  logic [N_CH*W-1:0] frame_q;
  logic              frame_done;
  logic              sync_err;
  logic              locked;
  logic [CW-1:0]     ch_cnt;

  tdm_demux_if #(.W(W)) bus ();

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dout       (dout),
    .ch_valid   (ch_valid),
    .frame_q    (frame_q),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked),
    .ch_cnt     (ch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH*W-1:0] dout;
    logic [N_CH-1:0]   chv;
    logic [N_CH*W-1:0] fq;
    logic              fd;
    logic              se;
    logic              lk;
    logic [CW-1:0]     cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;
  int fd_seen = 0;

  // Reference model state
  bit                m_lock;
  int                m_cnt;
  logic [W-1:0]      m_ch[N_CH];
  logic [N_CH*W-1:0] m_frame;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N_CH*W-1:0] pack_ch();
    logic [N_CH*W-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*W +: W] = m_ch[k];
    return v;
  endfunction

  task automatic beat(input bit rst, input bit v, input bit s, input logic [W-1:0] d);
    exp_t e;
    exp_t o;
    e.chv = '0;
    e.fd  = 1'b0;
    e.se  = 1'b0;
    if (rst) begin
      m_lock = 1'b0;
      m_cnt  = 0;
      for (int k = 0; k < N_CH; k++) m_ch[k] = '0;
      m_frame = '0;
    end else if (v) begin
      if (s) begin
        e.se    = m_lock && (m_cnt != 0);
        m_ch[0] = d;
        e.chv   = N_CH'(1);
        m_cnt   = 1;
        m_lock  = 1'b1;
      end else if (m_lock) begin
        m_ch[m_cnt] = d;
        e.chv       = N_CH'(1) << m_cnt;
        if (m_cnt == N_CH - 1) begin
          m_frame = pack_ch();
          e.fd    = 1'b1;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
    end
    e.dout = pack_ch();
    e.fq   = m_frame;
    e.lk   = m_lock;
    e.cnt  = CW'(m_cnt);
    sb_q.push_back(e);

    rst_n          = ~rst;
    bus.din_valid  = v;
    bus.frame_sync = s;
    bus.din        = d;
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check("dout",       64'(dout),       64'(o.dout));
    check("ch_valid",   64'(ch_valid),   64'(o.chv));
    check("frame_q",    64'(frame_q),    64'(o.fq));
    check("frame_done", 64'(frame_done), 64'(o.fd));
    check("sync_err",   64'(sync_err),   64'(o.se));
    check("locked",     64'(locked),     64'(o.lk));
    check("ch_cnt",     64'(ch_cnt),     64'(o.cnt));
    if (frame_done === 1'b1) fd_seen++;
  endtask

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.frame_sync = 1'b0;
    #1;

    // 1. Reset held for two clocks, then an unsynced sample is ignored
    beat(1, 0, 0, 8'h00);
    beat(1, 0, 0, 8'h00);
    check("rst_dout",   64'(dout),   64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    beat(0, 1, 0, 8'hAA);
    check("hunt_ignore_dout", 64'(dout), 64'h0);

    // 2. Lock and fill one frame
    fd_seen = 0;
    beat(0, 1, 1, 8'h11);
    check("t2_chv0", 64'(ch_valid), 64'h1);
    beat(0, 1, 0, 8'h22);
    check("t2_chv1", 64'(ch_valid), 64'h2);
    beat(0, 1, 0, 8'h33);
    check("t2_chv2", 64'(ch_valid), 64'h4);
    beat(0, 1, 0, 8'h44);
    check("t2_chv3", 64'(ch_valid), 64'h8);
    check("t2_frame_q", 64'(frame_q), 64'h44332211);
    check("t2_fd_count", 64'(fd_seen), 64'd1);

    // 3. Wrap to channel 0 without sync
    beat(0, 1, 0, 8'h55);
    check("t3_ch0",      64'(dout[7:0]), 64'h55);
    check("t3_ch_cnt",   64'(ch_cnt),    64'd1);
    check("t3_sync_err", 64'(sync_err),  64'h0);

    // 4. Early sync after two samples of a frame
    beat(0, 1, 0, 8'h77);
    beat(0, 1, 1, 8'h66);
    check("t4_sync_err", 64'(sync_err),  64'h1);
    check("t4_ch0",      64'(dout[7:0]), 64'h66);
    check("t4_ch_cnt",   64'(ch_cnt),    64'd1);
    check("t4_frame_q",  64'(frame_q),   64'h44332211);
    beat(0, 0, 0, 8'h00);
    check("t4_err_pulse", 64'(sync_err), 64'h0);

    // 5. Gaps between samples
    fd_seen = 0;
    beat(0, 1, 1, 8'hA0);
    beat(0, 0, 1, 8'hEE);
    beat(0, 1, 0, 8'hA1);
    beat(0, 0, 0, 8'hEF);
    beat(0, 0, 0, 8'hEF);
    beat(0, 1, 0, 8'hA2);
    beat(0, 0, 0, 8'h00);
    beat(0, 1, 0, 8'hA3);
    check("t5_frame_q",  64'(frame_q), 64'hA3A2A1A0);
    check("t5_fd_count", 64'(fd_seen), 64'd1);
    beat(0, 0, 0, 8'h00);
    check("t5_gap_fd", 64'(frame_done), 64'h0);

    // 6. Reset mid-frame, then unsynced samples ignored until sync
    beat(0, 1, 1, 8'hB0);
    beat(0, 1, 0, 8'hB1);
    beat(1, 1, 0, 8'hB2);
    check("t6_frame_q", 64'(frame_q), 64'h0);
    check("t6_locked",  64'(locked),  64'h0);
    beat(0, 1, 0, 8'hC0);
    beat(0, 1, 0, 8'hC1);
    check("t6_dout", 64'(dout), 64'h0);
    beat(0, 1, 1, 8'hD0);
    check("t6_relock", 64'(locked), 64'h1);

    // Random traffic with occasional (often misplaced) syncs
    for (int i = 0; i < 200; i++) begin
      beat(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           W'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
